// File: rtl/clint_timer.sv
// clint_timer: APB completer implementing the RISC-V machine timer and
// machine software interrupt (CLINT subset).
//
// Register map (byte offsets, 32-bit words, decoded from paddr[15:0]):
//   0x0000  msip         bit0 r/w, bits 31:1 read 0
//   0x4000  mtimecmp_lo
//   0x4004  mtimecmp_hi
//   0xBFF8  mtime_lo
//   0xBFFC  mtime_hi
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   psel, penable       APB select / access phase
//   pready              APB ready (zero wait states)
//   paddr, pwrite       byte address, 1 = write
//   pwdata, pwstrb      write data, byte-lane strobes
//   prdata, pslverr     read data, error response
//   int_m_timer         machine timer interrupt (registered mtime >= mtimecmp)
//   int_m_soft          machine software interrupt (msip bit)
//
// Parameters:
//   ADDR_W    width of paddr (must be >= 16)
//   TICK_DIV  clk cycles per mtime increment, 1..65535
module clint_timer #(
  parameter int ADDR_W   = 16,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  output logic              pready,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pwstrb,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic              int_m_timer,
  output logic              int_m_soft
);

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTCMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTCMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

  localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [15:0] cnt;

  logic [15:0] offset;
  logic        access;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic        mapped;
  logic        err;
  logic        wr_en;
  logic        tick;

  // Byte-lane merge of a write into an existing 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign offset = paddr[15:0];

  // Reset masks the handshake so no response is visible while rst is high.
  assign access = psel & penable & ~rst;

  assign sel_msip    = (offset == OFF_MSIP);
  assign sel_cmp_lo  = (offset == OFF_MTCMP_LO);
  assign sel_cmp_hi  = (offset == OFF_MTCMP_HI);
  assign sel_time_lo = (offset == OFF_MTIME_LO);
  assign sel_time_hi = (offset == OFF_MTIME_HI);
  assign mapped      = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

  assign err     = access & (~mapped | (offset[1:0] != 2'b00));
  assign pready  = access;
  assign pslverr = err;
  assign wr_en   = access & pwrite & ~err;

  assign tick = (cnt == CNT_LAST);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    prdata = 32'h0;
    if (access && !pwrite && !err) begin
      unique case (1'b1)
        sel_msip:    prdata = {31'h0, msip};
        sel_cmp_lo:  prdata = mtimecmp[31:0];
        sel_cmp_hi:  prdata = mtimecmp[63:32];
        sel_time_lo: prdata = mtime[31:0];
        sel_time_hi: prdata = mtime[63:32];
        default:     prdata = 32'h0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= 64'h0;
      cnt   <= 16'h0;
    end else if (wr_en && sel_time_lo) begin
      // A software write wins over the tick; the prescaler restarts so the
      // written value is held for a full TICK_DIV period.
      mtime[31:0] <= merge_bytes(mtime[31:0], pwdata, pwstrb);
      cnt         <= 16'h0;
    end else if (wr_en && sel_time_hi) begin
      mtime[63:32] <= merge_bytes(mtime[63:32], pwdata, pwstrb);
      cnt          <= 16'h0;
    end else if (tick) begin
      // Single 64-bit add: the low-to-high carry lands in the same edge.
      mtime <= mtime + 64'd1;
      cnt   <= 16'h0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (wr_en) begin
      if (sel_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], pwdata, pwstrb);
      if (sel_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], pwdata, pwstrb);
      if (sel_msip && pwstrb[0]) msip <= pwdata[0];
    end
  end

  // Compares the current register values, so the interrupt follows any
  // change to mtime or mtimecmp one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_m_timer <= 1'b0;
    else     int_m_timer <= (mtime >= mtimecmp);
  end

  assign int_m_soft = msip;

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- APB completer implementing the RISC-V machine timer and software interrupt (CLINT subset). It is attached to the APB fabric as a third target alongside RAM and UART.
- Holds a free-running 64-bit mtime, a 64-bit mtimecmp and the msip bit.
- Drives the core's machine timer and software interrupt lines.

Parameters:
- ADDR_W, 16, width of paddr; the register map decodes paddr[15:0].
- TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- psel  input  1  APB select
- penable  input  1  APB access phase
- pready  output  1  APB ready
- paddr  input  ADDR_W  byte address
- pwrite  input  1  1 = write
- pwdata  input  32  write data
- pwstrb  input  4  byte-lane write strobes
- prdata  output  32  read data
- pslverr  output  1  error response
- int_m_timer  output  1  machine timer interrupt, registered
- int_m_soft  output  1  machine software interrupt (the msip bit)

Behaviour:
- Reset (rst high, asynchronous) sets:
  - mtime = 0, prescaler = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0;
  - int_m_timer = 0, int_m_soft = 0, pready = 0, prdata = 0, pslverr = 0.
- Register map (byte offsets, 32-bit words):
  - 0x0000 msip: bit0 is read/write, bits 31:1 read 0 and ignore writes;
  - 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32];
  - 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32].
- APB handshake:
  - Zero wait states: pready = psel & penable, combinational.
  - In the access phase, prdata = the selected register for reads and 0 for writes.
  - prdata = 0 outside the access phase.
- Errors:
  - pslverr = psel & penable & (unmapped offset | paddr[1:0] != 0).
  - An erroring write has no side effect; an erroring read returns 0.
- Writes:
  - A write commits at the rising edge ending the access phase (psel & penable & pwrite & ~pslverr).
  - Each byte lane updates only where pwstrb[i] = 1; pwstrb = 0 commits nothing but still completes with pready.
- Prescaler:
  - Counter cnt runs 0..TICK_DIV-1.
  - When cnt == TICK_DIV-1, cnt wraps to 0 and mtime increments by 1 in the same edge.
  - With TICK_DIV = 1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0 with no flag.
  - The low-to-high carry is a true 64-bit add, with no cross-word glitch.
- Write to mtime (either word):
  - The written bytes take the written value.
  - The non-written bytes of that word, and the other word, keep their current (pre-increment) value; the increment is suppressed that edge.
  - cnt is cleared to 0. The written value is what reads back next cycle.
- Timer interrupt: int_m_timer is registered as (mtime >= mtimecmp), unsigned 64-bit compare of the current register values. It therefore lags a register change by exactly one cycle.
  - Writing mtimecmp to a value above mtime deasserts int_m_timer on the cycle after the write edge.
  - int_m_timer is level-sensitive only; there is no latching or clearing.
- Software interrupt: int_m_soft = msip register output, direct. It changes on the write edge.
- Non-atomic access:
  - Reading mtime_hi then mtime_lo is not atomic.
  - Software uses the hi/lo/hi re-read loop; hardware provides no snapshot.
- Back-to-back transfers: every setup/access pair is independent, and penable without psel is ignored.
- Reset mid-transfer: rst during the access phase aborts the transfer (no commit), and all state returns to its reset values.

Test Plan:
- Reset then idle, TICK_DIV = 1: after 10 cycles, a read of 0xBFF8 returns 10 + (cycles elapsed through the read phase), and 0xBFFC = 0. int_m_timer stays 0 and mtimecmp reads 0xFFFFFFFF / 0xFFFFFFFF.
- Write 0x4004 = 0 and 0x4000 = 0x20: int_m_timer rises exactly one cycle after mtime reaches 0x20. A following write 0x4000 = 0xFFFFFFFF drops it one cycle after that write.
- Write 0xBFF8 = 0xFFFFFFFF, pwstrb = 4'hF: two cycles later 0xBFFC reads 1 and 0xBFF8 reads 1 (carry verified). Separately, with mtime forced to all-ones, the next increment wraps to 0.
- TICK_DIV = 4: mtime advances by 1 every 4 clk edges. Writing mtime = 0x100 mid-count gives 0x100 held for 4 cycles, then 0x101.
- Write 0x0000 = 0x3 with pwstrb = 4'h1: int_m_soft = 1 and the read returns 0x1. Writing 0x0 clears it. Writing with pwstrb = 0 leaves it unchanged.
- Read 0x0008 and write 0x4002: pslverr = 1 with pready = 1, prdata = 0, and no register changes. Asserting rst during a write access phase leaves msip = 0 and mtime = 0.
